// File: rtl/mem_port_arb_pkg.sv
// Shared FSM encoding and owner identifiers for the unified IF/DM memory port arbiter.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_IF = 2'd1,
        ST_WAIT_DM = 2'd2
    } state_t;

    // Bit positions inside the one-hot grant vector.
    localparam int OWN_IF     = 0;
    localparam int OWN_DM     = 1;
    localparam int NUM_OWNERS = 2;

endpackage

// File: rtl/mem_port_arb_sel.sv
// Combinational grant selector: data normally wins, fetch wins once the data streak saturates.
module mem_arb_sel
    import mem_port_arb_pkg::*;
(
    input  logic                  if_req,
    input  logic                  if_flush,
    input  logic                  dm_req,
    input  logic                  streak_sat,
    output logic [NUM_OWNERS-1:0] grant
);

    always_comb begin
        grant = '0;
        if (dm_req && !(if_req && streak_sat)) begin
            grant[OWN_DM] = 1'b1;
        end else if (if_req && !if_flush) begin
            grant[OWN_IF] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight,
// with a bounded number of back-to-back data grants while a fetch is waiting.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    input  logic          i_if_flush,
    output logic [DW-1:0] o_if_rdata,
    output logic          o_if_valid,
    output logic          o_if_stall,
    input  logic          i_dm_req,
    input  logic          i_dm_wen,
    input  logic [AW-1:0] i_dm_addr,
    input  logic [DW-1:0] i_dm_wdata,
    input  logic [DW/8-1:0] i_dm_mask,
    output logic [DW-1:0] o_dm_rdata,
    output logic          o_dm_valid,
    output logic          o_dm_stall,
    output logic          o_mem_req,
    output logic          o_mem_wen,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [DW/8-1:0] o_mem_mask,
    input  logic          i_mem_ready,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    state_t                  state, state_nxt;
    logic [SW-1:0]           streak, streak_nxt;
    logic                    discard, discard_nxt;
    logic                    streak_sat;
    logic [NUM_OWNERS-1:0]   grant;

    assign streak_sat = (streak == STREAK_MAX);

    mem_arb_sel u_sel (
        .if_req     (i_if_req),
        .if_flush   (i_if_flush),
        .dm_req     (i_dm_req),
        .streak_sat (streak_sat),
        .grant      (grant)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            streak  <= '0;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            streak  <= streak_nxt;
            discard <= discard_nxt;
        end
    end

    // Everything is forced quiet while reset is held so a half-finished transaction leaks nothing.
    always_comb begin
        state_nxt   = state;
        streak_nxt  = streak;
        discard_nxt = discard;
        o_mem_req   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_mask  = '0;
        o_if_valid  = 1'b0;
        o_if_rdata  = '0;
        o_dm_valid  = 1'b0;
        o_dm_rdata  = '0;
        if (!i_rst) begin
            unique case (state)
                ST_IDLE: begin
                    if (grant[OWN_DM]) begin
                        o_mem_req   = 1'b1;
                        o_mem_wen   = i_dm_wen;
                        o_mem_addr  = i_dm_addr;
                        o_mem_wdata = i_dm_wdata;
                        o_mem_mask  = i_dm_mask;
                    end else if (grant[OWN_IF]) begin
                        o_mem_req   = 1'b1;
                        o_mem_addr  = i_if_addr;
                        o_mem_mask  = '1;
                    end
                    // The streak only advances on grants the memory actually took.
                    if (o_mem_req && i_mem_ready) begin
                        if (grant[OWN_DM]) begin
                            state_nxt = ST_WAIT_DM;
                            if (i_if_req && !streak_sat) begin
                                streak_nxt = streak + 1'b1;
                            end
                        end else begin
                            state_nxt  = ST_WAIT_IF;
                            streak_nxt = '0;
                        end
                    end
                end
                ST_WAIT_IF: begin
                    if (i_mem_rvalid) begin
                        o_if_valid  = !discard;
                        o_if_rdata  = i_mem_rdata;
                        discard_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end else if (i_if_flush) begin
                        discard_nxt = 1'b1;
                    end
                end
                ST_WAIT_DM: begin
                    if (i_mem_rvalid) begin
                        o_dm_valid = 1'b1;
                        o_dm_rdata = i_mem_rdata;
                        state_nxt  = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
            if (!i_if_req) begin
                streak_nxt = '0;
            end
        end
    end

    assign o_if_stall = i_if_req & ~o_if_valid & ~i_rst;
    assign o_dm_stall = i_dm_req & ~o_dm_valid & ~i_rst;

endmodule

// File: tb/tb_mem_port_arb.sv
// Scoreboard bench for mem_port_arb: requesters push expected transactions, a memory
// responder serves the port, and a monitor checks arbitration, routing and stalls.
module tb_mem_port_arb;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MW   = DW / 8;
    localparam int MAXS = 4;
    localparam int OWN_IF_LOG = 1;
    localparam int OWN_DM_LOG = 2;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] mask;
        logic [DW-1:0] rdata;
    } txn_t;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] o_if_rdata;
    logic          o_if_valid;
    logic          o_if_stall;
    logic          dm_req;
    logic          dm_wen;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [MW-1:0] dm_mask;
    logic [DW-1:0] o_dm_rdata;
    logic          o_dm_valid;
    logic          o_dm_stall;
    logic          o_mem_req;
    logic          o_mem_wen;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [MW-1:0] o_mem_mask;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    txn_t          if_q[$];
    txn_t          dm_q[$];
    int            grant_log[$];
    logic [DW-1:0] ref_mem[logic [AW-1:0]];
    logic [DW-1:0] mem_arr[logic [AW-1:0]];

    int            lat_force         = 0;
    bit            ready_rand        = 1'b0;
    int            ready_block_until = 0;
    int            last_run          = 0;
    int            accept_cyc        = 0;
    int            last_valid_cyc    = 0;
    logic [DW-1:0] last_if_rdata     = '0;

    mem_port_arb #(.AW(AW), .DW(DW), .MAX_DM_STREAK(MAXS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .i_if_flush  (if_flush),
        .o_if_rdata  (o_if_rdata),
        .o_if_valid  (o_if_valid),
        .o_if_stall  (o_if_stall),
        .i_dm_req    (dm_req),
        .i_dm_wen    (dm_wen),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .i_dm_mask   (dm_mask),
        .o_dm_rdata  (o_dm_rdata),
        .o_dm_valid  (o_dm_valid),
        .o_dm_stall  (o_dm_stall),
        .o_mem_req   (o_mem_req),
        .o_mem_wen   (o_mem_wen),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_mask  (o_mem_mask),
        .i_mem_ready (mem_ready),
        .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] seed_word(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) begin
            if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic int logCode(input int q[$]);
        int c;
        c = 0;
        foreach (q[i]) c = c * 4 + q[i];
        return c;
    endfunction

    function automatic logic [159:0] allOutputs();
        return {o_if_rdata, o_if_valid, o_if_stall, o_dm_rdata, o_dm_valid, o_dm_stall,
                o_mem_req, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_mask};
    endfunction

    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory side: a word store with byte masks, a random or forced response latency and
    // optional backpressure. It keeps finishing an accepted access even across a DUT reset.
    initial begin : responder
        bit            pending;
        int            cnt;
        logic [DW-1:0] word;
        logic [DW-1:0] rsp;
        pending    = 1'b0;
        cnt        = 0;
        rsp        = '0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_arr[32'h100] = 32'h0050_0093;
        forever begin
            @(negedge clk);
            if (!rst && o_mem_req && mem_ready) begin
                word = mem_arr.exists(o_mem_addr) ? mem_arr[o_mem_addr] : seed_word(o_mem_addr);
                if (o_mem_wen) begin
                    word = merge(word, o_mem_wdata, o_mem_mask);
                    mem_arr[o_mem_addr] = word;
                end
                rsp     = word;
                pending = 1'b1;
                cnt     = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 2));
            end
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pending) begin
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rsp;
                    pending    = 1'b0;
                end else begin
                    cnt = cnt - 1;
                end
            end
            mem_ready = (cyc >= ready_block_until) && (!ready_rand || ($urandom_range(0, 3) != 0));
        end
    end

    // Transaction-level reference: at most one access in flight, data preferred unless a
    // fetch has already watched MAXS data grants go by; responses go back to their owner.
    initial begin : monitor
        int   m_busy;
        int   m_streak;
        bit   m_discard;
        bit   exp_dm, exp_if, exp_ifv, exp_dmv;
        int   run;
        txn_t t;
        m_busy    = 0;
        m_streak  = 0;
        m_discard = 1'b0;
        run       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy    = 0;
                m_streak  = 0;
                m_discard = 1'b0;
                run       = 0;
                continue;
            end
            exp_ifv = 1'b0;
            exp_dmv = 1'b0;
            if (m_busy != 0) begin
                checkOutput("mem_req_while_busy", o_mem_req, 1'b0);
                if (mem_rvalid) begin
                    if (m_busy == OWN_IF_LOG) exp_ifv = !m_discard;
                    else exp_dmv = 1'b1;
                    m_busy    = 0;
                    m_discard = 1'b0;
                end else if (m_busy == OWN_IF_LOG && if_flush) begin
                    m_discard = 1'b1;
                end
            end else begin
                exp_dm = dm_req && !(if_req && m_streak == MAXS);
                exp_if = !exp_dm && if_req && !if_flush;
                checkOutput("mem_req", o_mem_req, exp_dm || exp_if);
                if (o_mem_req && (exp_dm || exp_if)) begin
                    if (exp_dm) begin
                        checkOutput("dm_q_nonempty", dm_q.size() != 0, 1'b1);
                        if (dm_q.size() != 0) begin
                            t = dm_q[0];
                            checkOutput("dm_mem_addr", o_mem_addr, t.addr);
                            checkOutput("dm_mem_wen", o_mem_wen, t.wen);
                            checkOutput("dm_mem_mask", o_mem_mask, t.mask);
                            if (t.wen) checkOutput("dm_mem_wdata", o_mem_wdata, t.wdata);
                        end
                    end else begin
                        checkOutput("if_q_nonempty", if_q.size() != 0, 1'b1);
                        if (if_q.size() != 0) begin
                            t = if_q[0];
                            checkOutput("if_mem_addr", o_mem_addr, t.addr);
                            checkOutput("if_mem_wen", o_mem_wen, 1'b0);
                            checkOutput("if_mem_mask", o_mem_mask, {MW{1'b1}});
                        end
                    end
                    run = run + 1;
                    if (mem_ready) begin
                        grant_log.push_back(exp_dm ? OWN_DM_LOG : OWN_IF_LOG);
                        last_run   = run;
                        run        = 0;
                        accept_cyc = cyc;
                        m_busy     = exp_dm ? OWN_DM_LOG : OWN_IF_LOG;
                        if (exp_if) m_streak = 0;
                        else if (if_req && m_streak < MAXS) m_streak = m_streak + 1;
                    end
                end
            end
            if (!if_req) m_streak = 0;
            checkOutput("if_valid", o_if_valid, exp_ifv);
            checkOutput("dm_valid", o_dm_valid, exp_dmv);
            if (exp_ifv && o_if_valid && if_q.size() != 0) begin
                checkOutput("if_rdata", o_if_rdata, if_q[0].rdata);
                last_if_rdata  = o_if_rdata;
                last_valid_cyc = cyc;
                void'(if_q.pop_front());
            end
            if (exp_dmv && o_dm_valid && dm_q.size() != 0) begin
                checkOutput("dm_rdata", o_dm_rdata, dm_q[0].rdata);
                last_valid_cyc = cyc;
                void'(dm_q.pop_front());
            end
            checkOutput("if_stall", o_if_stall, if_req && !exp_ifv);
            checkOutput("dm_stall", o_dm_stall, dm_req && !exp_dmv);
        end
    end

    // Issues one request, records what it should look like and return, holds it until the
    // matching valid pulse, then drops it at the start of the following cycle.
    task automatic applyStimulus(input bit is_dm, input logic wen, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [MW-1:0] mask);
        txn_t          t;
        logic [DW-1:0] word;
        int            waited;
        word = ref_mem.exists(addr) ? ref_mem[addr] : seed_word(addr);
        if (is_dm && wen) begin
            word = merge(word, wdata, mask);
            ref_mem[addr] = word;
        end
        t.wen   = is_dm ? wen : 1'b0;
        t.addr  = addr;
        t.wdata = wdata;
        t.mask  = is_dm ? mask : {MW{1'b1}};
        t.rdata = word;
        if (is_dm) begin
            dm_q.push_back(t);
            dm_wen   = wen;
            dm_addr  = addr;
            dm_wdata = wdata;
            dm_mask  = mask;
            dm_req   = 1'b1;
        end else begin
            if_q.push_back(t);
            if_addr = addr;
            if_req  = 1'b1;
        end
        waited = 0;
        forever begin
            @(negedge clk);
            if ((is_dm ? o_dm_valid : o_if_valid) || waited >= 200) break;
            waited = waited + 1;
        end
        checkOutput(is_dm ? "dm_timeout" : "if_timeout", waited >= 200, 1'b0);
        @(posedge clk);
        #1;
        if (is_dm) dm_req = 1'b0;
        else if_req = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    initial begin : main
        int            exp_log[$];
        int            waited;
        logic [DW-1:0] old_word;
        txn_t          t;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        if_flush = 1'b0;
        dm_req   = 1'b0;
        dm_wen   = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        dm_mask  = '0;
        ref_mem[32'h100] = 32'h0050_0093;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", allOutputs(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_outputs", allOutputs(), '0);
        @(posedge clk);
        #1;

        $display("[TB] fetch only");
        lat_force = 0;
        applyStimulus(1'b0, 1'b0, 32'h100, '0, '0);
        checkOutput("fetch_req_cycles", last_run, 1);
        checkOutput("fetch_latency", last_valid_cyc - accept_cyc, 1);
        checkOutput("fetch_rdata", last_if_rdata, 32'h0050_0093);

        $display("[TB] simultaneous requests");
        grant_log.delete();
        fork
            applyStimulus(1'b0, 1'b0, 32'h104, '0, '0);
            applyStimulus(1'b1, 1'b0, 32'h2000, '0, 4'hF);
        join
        exp_log = '{OWN_DM_LOG, OWN_IF_LOG};
        checkOutput("simul_grant_order", logCode(grant_log), logCode(exp_log));

        $display("[TB] starvation bound");
        grant_log.delete();
        fork
            applyStimulus(1'b0, 1'b0, 32'h300, '0, '0);
            for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h2000 + 4 * i, '0, 4'hF);
        join
        exp_log.delete();
        for (int i = 0; i < MAXS; i++) exp_log.push_back(OWN_DM_LOG);
        exp_log.push_back(OWN_IF_LOG);
        for (int i = MAXS; i < 6; i++) exp_log.push_back(OWN_DM_LOG);
        checkOutput("starve_grant_order", logCode(grant_log), logCode(exp_log));

        $display("[TB] flush in idle and in wait");
        grant_log.delete();
        lat_force = 2;
        t.wen   = 1'b0;
        t.addr  = 32'h180;
        t.wdata = '0;
        t.mask  = {MW{1'b1}};
        t.rdata = seed_word(32'h180);
        if_q.push_back(t);
        if_addr  = 32'h180;
        if_req   = 1'b1;
        if_flush = 1'b1;
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        waited = 0;
        forever begin
            @(negedge clk);
            if ((o_mem_req && mem_ready) || waited >= 50) break;
            waited = waited + 1;
        end
        checkOutput("flush_accept_timeout", waited >= 50, 1'b0);
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        if_addr  = 32'h200;
        void'(if_q.pop_back());
        t.addr  = 32'h200;
        t.rdata = seed_word(32'h200);
        if_q.push_back(t);
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        waited = 0;
        forever begin
            @(negedge clk);
            if (o_if_valid || waited >= 50) break;
            waited = waited + 1;
        end
        checkOutput("flush_refetch_timeout", waited >= 50, 1'b0);
        checkOutput("flush_refetch_rdata", o_if_rdata, seed_word(32'h200));
        @(posedge clk);
        #1;
        if_req = 1'b0;
        exp_log = '{OWN_IF_LOG, OWN_IF_LOG};
        checkOutput("flush_grant_order", logCode(grant_log), logCode(exp_log));
        checkOutput("flush_if_q_drained", if_q.size(), 0);

        $display("[TB] backpressure store");
        lat_force = 0;
        ready_block_until = cyc + 4;
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'h3);
        checkOutput("bp_req_cycles", last_run, 4);

        $display("[TB] reset mid transaction");
        lat_force = 4;
        old_word = '0;
        t.wen   = 1'b0;
        t.addr  = 32'h2100;
        t.wdata = '0;
        t.mask  = 4'hF;
        t.rdata = seed_word(32'h2100);
        dm_q.push_back(t);
        dm_wen  = 1'b0;
        dm_addr = 32'h2100;
        dm_mask = 4'hF;
        dm_req  = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if ((o_mem_req && mem_ready) || waited >= 50) break;
            waited = waited + 1;
        end
        checkOutput("rst_accept_timeout", waited >= 50, 1'b0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        dm_req = 1'b0;
        dm_q.delete();
        @(negedge clk);
        checkOutput("rst_mid_outputs", allOutputs(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waited = 0;
        forever begin
            @(negedge clk);
            if (mem_rvalid || waited >= 20) break;
            old_word = allOutputs() == '0 ? old_word : 32'h1;
            waited = waited + 1;
        end
        checkOutput("stale_rvalid_seen", waited >= 20, 1'b0);
        checkOutput("stale_rvalid_outputs", allOutputs(), '0);
        checkOutput("post_rst_quiet", old_word, '0);
        @(posedge clk);
        #1;

        $display("[TB] randomized traffic");
        lat_force  = -1;
        ready_rand = 1'b1;
        fork
            for (int i = 0; i < 40; i++) begin
                idleCycles($urandom_range(0, 2));
                applyStimulus(1'b0, 1'b0, 32'h100 + 4 * $urandom_range(0, 63), '0, '0);
            end
            for (int i = 0; i < 60; i++) begin
                idleCycles($urandom_range(0, 1));
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 32'h1000 + 4 * $urandom_range(0, 15),
                              $urandom, 4'($urandom_range(0, 15)));
            end
        join
        repeat (3) @(posedge clk);
        checkOutput("final_if_q_drained", if_q.size(), 0);
        checkOutput("final_dm_q_drained", dm_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
